// File: rtl/chunked_adder.sv
// Multi-cycle wide adder: adds two WIDTH*CHUNKS-bit operands one WIDTH-bit chunk
// per clock, least-significant chunk first, with the carry held in a register.
module chunked_adder #(
    parameter int WIDTH  = 4,
    parameter int CHUNKS = 4
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_valid,
    output logic                      o_ready,
    input  logic [WIDTH*CHUNKS-1:0]   i_data0,
    input  logic [WIDTH*CHUNKS-1:0]   i_data1,
    input  logic                      i_carry,
    output logic                      o_valid,
    input  logic                      i_ready,
    output logic [WIDTH*CHUNKS-1:0]   o_sum,
    output logic                      o_carry,
    output logic                      o_busy
);
    localparam int TW = WIDTH * CHUNKS;
    localparam int IW = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam logic [IW-1:0] LAST_IDX   = IW'(CHUNKS - 1);
    localparam logic [TW-1:0] CHUNK_MASK = TW'({WIDTH{1'b1}});

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state;
    state_t           state_next;
    logic [TW-1:0]    op_a;
    logic [TW-1:0]    op_b;
    logic [TW-1:0]    work;
    logic [TW-1:0]    work_next;
    logic             carry_reg;
    logic [IW-1:0]    idx;
    logic [31:0]      shift;
    logic [WIDTH-1:0] a_chunk;
    logic [WIDTH-1:0] b_chunk;
    logic [WIDTH:0]   chunk_res;

    function automatic logic [WIDTH:0] add_chunk(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b,
                                                 input logic             c);
        return {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c};
    endfunction

    // Handshake outputs depend on state alone, so no input reaches them combinationally.
    assign o_ready = (state == IDLE);
    assign o_valid = (state == DONE);
    assign o_busy  = (state != IDLE);

    always_comb begin
        shift     = 32'(idx) * 32'(WIDTH);
        a_chunk   = WIDTH'(op_a >> shift);
        b_chunk   = WIDTH'(op_b >> shift);
        chunk_res = add_chunk(a_chunk, b_chunk, carry_reg);
        work_next = (work & ~(CHUNK_MASK << shift)) | (TW'(chunk_res[WIDTH-1:0]) << shift);
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (i_valid) state_next = CALC;
            CALC:    if (idx == LAST_IDX) state_next = DONE;
            DONE:    if (i_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The visible result only moves on the final chunk, so it holds through CALC.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            op_a      <= '0;
            op_b      <= '0;
            work      <= '0;
            carry_reg <= 1'b0;
            idx       <= '0;
            o_sum     <= '0;
            o_carry   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        op_a      <= i_data0;
                        op_b      <= i_data1;
                        carry_reg <= i_carry;
                        work      <= '0;
                        idx       <= '0;
                    end
                end
                CALC: begin
                    work      <= work_next;
                    carry_reg <= chunk_res[WIDTH];
                    if (idx == LAST_IDX) begin
                        o_sum   <= work_next;
                        o_carry <= chunk_res[WIDTH];
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_chunked_adder.sv
// Scoreboard bench for chunked_adder: directed cases on a (4,4) instance plus
// random traffic on (4,4), (8,1) and (3,5) instances.
module tb_chunked_adder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        vld    [3];
    logic [15:0] d0     [3];
    logic [15:0] d1     [3];
    logic        cin    [3];
    logic        rdy_in [3];
    logic        rdy_o  [3];
    logic        val_o  [3];
    logic        busy_o [3];
    logic        co_o   [3];
    logic [15:0] sum_o  [3];
    logic [15:0] s0;
    logic [7:0]  s1;
    logic [14:0] s2;
    int          tw     [3] = '{16, 8, 15};

    logic [16:0] q0[$];
    logic [16:0] q1[$];
    logic [16:0] q2[$];
    int          in_cnt  [3] = '{0, 0, 0};
    int          out_cnt [3] = '{0, 0, 0};
    logic        held     [3] = '{1'b0, 1'b0, 1'b0};
    logic [15:0] held_sum [3];
    logic        held_co  [3];
    int          assert_cnt = 0;
    int          fail_cnt   = 0;
    logic        rand_rdy   = 1'b0;

    chunked_adder #(.WIDTH(4), .CHUNKS(4)) dut0 (
        .i_clk(clk), .i_rst(rst), .i_valid(vld[0]), .o_ready(rdy_o[0]),
        .i_data0(d0[0]), .i_data1(d1[0]), .i_carry(cin[0]), .o_valid(val_o[0]),
        .i_ready(rdy_in[0]), .o_sum(s0), .o_carry(co_o[0]), .o_busy(busy_o[0]));

    chunked_adder #(.WIDTH(8), .CHUNKS(1)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_valid(vld[1]), .o_ready(rdy_o[1]),
        .i_data0(d0[1][7:0]), .i_data1(d1[1][7:0]), .i_carry(cin[1]), .o_valid(val_o[1]),
        .i_ready(rdy_in[1]), .o_sum(s1), .o_carry(co_o[1]), .o_busy(busy_o[1]));

    chunked_adder #(.WIDTH(3), .CHUNKS(5)) dut2 (
        .i_clk(clk), .i_rst(rst), .i_valid(vld[2]), .o_ready(rdy_o[2]),
        .i_data0(d0[2][14:0]), .i_data1(d1[2][14:0]), .i_carry(cin[2]), .o_valid(val_o[2]),
        .i_ready(rdy_in[2]), .o_sum(s2), .o_carry(co_o[2]), .o_busy(busy_o[2]));

    assign sum_o[0] = s0;
    assign sum_o[1] = {8'h00, s1};
    assign sum_o[2] = {1'b0, s2};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        assert_cnt++;
        if (act !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input int k, input logic [16:0] e);
        case (k)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
        in_cnt[k]++;
    endtask

    function automatic int qsize(input int k);
        case (k)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic logic [16:0] pop(input int k);
        case (k)
            0:       return q0.pop_front();
            1:       return q1.pop_front();
            default: return q2.pop_front();
        endcase
    endfunction

    // Monitor: a handshake at the next rising edge is seen at this falling edge.
    task automatic mon(input int k);
        logic [16:0] e;
        if (val_o[k]) begin
            if (held[k]) begin
                chk("stall_sum", 32'(sum_o[k]), 32'(held_sum[k]));
                chk("stall_carry", 32'(co_o[k]), 32'(held_co[k]));
            end
            if (rdy_in[k]) begin
                if (qsize(k) == 0) begin
                    chk("output_without_expectation", 32'(qsize(k)), 32'd1);
                end else begin
                    e = pop(k);
                    chk("sum", 32'(sum_o[k]), 32'(e[15:0]));
                    chk("carry", 32'(co_o[k]), 32'(e[16]));
                end
                out_cnt[k]++;
                held[k] = 1'b0;
            end else begin
                held[k]     = 1'b1;
                held_sum[k] = sum_o[k];
                held_co[k]  = co_o[k];
            end
        end else begin
            held[k] = 1'b0;
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) mon(k);
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) begin
                for (int k = 0; k < 3; k++) rdy_in[k] = ($urandom_range(0, 3) != 0);
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Called #1 after a rising edge; returns #1 after the accepting edge.
    task automatic send(input int k, input logic [15:0] a, input logic [15:0] b,
                        input logic c, input logic [16:0] e, input logic track);
        int n;
        n      = 0;
        vld[k] = 1'b1;
        d0[k]  = a;
        d1[k]  = b;
        cin[k] = c;
        @(negedge clk);
        while (!rdy_o[k] && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("accept_ready", 32'(rdy_o[k]), 32'd1);
        if (track) push(k, e);
        @(posedge clk);
        #1;
        vld[k] = 1'b0;
    endtask

    task automatic wait_valid(input int k);
        int n;
        n = 0;
        while (!val_o[k] && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("wait_valid", 32'(val_o[k]), 32'd1);
    endtask

    task automatic wait_idle(input int k);
        int n;
        n = 0;
        while (!rdy_o[k] && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("wait_idle", 32'(rdy_o[k]), 32'd1);
    endtask

    initial begin
        logic [16:0] mask;
        logic [16:0] full;
        logic [15:0] a;
        logic [15:0] b;
        logic        c;
        int          gap;
        int          n;

        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            vld[k] = 1'b0; d0[k] = '0; d1[k] = '0; cin[k] = 1'b0; rdy_in[k] = 1'b1;
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_ready", 32'(rdy_o[0]), 32'd1);
        chk("rst_valid", 32'(val_o[0]), 32'd0);
        chk("rst_busy", 32'(busy_o[0]), 32'd0);
        chk("rst_sum", 32'(sum_o[0]), 32'd0);
        chk("rst_carry", 32'(co_o[0]), 32'd0);

        // Basic add with latency check
        send(0, 16'h1234, 16'h4321, 1'b0, {1'b0, 16'h5555}, 1'b1);
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("latency_early_valid", 32'(val_o[0]), 32'd0);
        end
        @(posedge clk);
        #1;
        chk("latency_valid", 32'(val_o[0]), 32'd1);
        chk("done_busy", 32'(busy_o[0]), 32'd1);
        @(posedge clk);
        #1;
        chk("idle_after_handshake", 32'(rdy_o[0]), 32'd1);

        // Full ripple; previous sum must hold during CALC
        send(0, 16'hFFFF, 16'h0000, 1'b1, {1'b1, 16'h0000}, 1'b1);
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("calc_sum_hold", 32'(sum_o[0]), 32'h5555);
            chk("calc_ready", 32'(rdy_o[0]), 32'd0);
            chk("calc_busy", 32'(busy_o[0]), 32'd1);
        end
        wait_valid(0);
        wait_idle(0);

        // Max operands
        send(0, 16'hFFFF, 16'hFFFF, 1'b1, {1'b1, 16'hFFFF}, 1'b1);
        wait_valid(0);
        wait_idle(0);

        // Backpressure with an ignored concurrent request
        rdy_in[0] = 1'b0;
        send(0, 16'h00F0, 16'h0010, 1'b0, {1'b0, 16'h0100}, 1'b1);
        wait_valid(0);
        vld[0] = 1'b1; d0[0] = 16'h1111; d1[0] = 16'h2222; cin[0] = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
            chk("bp_valid", 32'(val_o[0]), 32'd1);
            chk("bp_sum", 32'(sum_o[0]), 32'h0100);
            chk("bp_ready", 32'(rdy_o[0]), 32'd0);
        end
        push(0, {1'b0, 16'h3333});
        rdy_in[0] = 1'b1;
        @(posedge clk);
        #1;
        chk("release_ready", 32'(rdy_o[0]), 32'd1);
        chk("release_valid", 32'(val_o[0]), 32'd0);
        @(posedge clk);
        #1;
        vld[0] = 1'b0;
        chk("next_accept_busy", 32'(busy_o[0]), 32'd1);
        wait_valid(0);
        wait_idle(0);

        // Reset in the middle of CALC
        send(0, 16'h0F0F, 16'h0101, 1'b0, 17'h0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst_ready", 32'(rdy_o[0]), 32'd1);
        chk("midrst_busy", 32'(busy_o[0]), 32'd0);
        chk("midrst_valid", 32'(val_o[0]), 32'd0);
        chk("midrst_sum", 32'(sum_o[0]), 32'd0);
        chk("midrst_carry", 32'(co_o[0]), 32'd0);
        send(0, 16'h0001, 16'h0001, 1'b0, {1'b0, 16'h0002}, 1'b1);
        wait_valid(0);
        wait_idle(0);

        // Random traffic on every configuration
        rand_rdy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            mask = (17'd1 << tw[k]) - 17'd1;
            for (int i = 0; i < 350; i++) begin
                gap = $urandom_range(0, 2);
                repeat (gap) begin
                    @(posedge clk);
                    #1;
                end
                a    = 16'($urandom) & mask[15:0];
                b    = 16'($urandom) & mask[15:0];
                c    = 1'($urandom_range(0, 1));
                full = {1'b0, a} + {1'b0, b} + {16'h0000, c};
                send(k, a, b, c, {full[tw[k]], full[15:0] & mask[15:0]}, 1'b1);
            end
            n = 0;
            while (qsize(k) != 0 && n < 500) begin
                @(posedge clk);
                #1;
                n++;
            end
            chk("drain", 32'(qsize(k)), 32'd0);
            chk("handshake_count", 32'(out_cnt[k]), 32'(in_cnt[k]));
        end
        rand_rdy = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end
endmodule
